// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 hex keypad scanner.
//   state_e        : scanner FSM states
//   KEY_MAP        : hex value of each key, indexed by {row, col}
//   onehot_row_idx : decodes active-high row hits into a row index,
//                    valid only when exactly one row is active
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    // Index {row, col}. Ascending range, so the first entry is row 0 / col 0.
    localparam logic [0:15][3:0] KEY_MAP = {
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } row_hit_t;

    function automatic row_hit_t onehot_row_idx(input logic [3:0] rows_low);
        row_hit_t res;
        res.hit = 1'b1;
        res.idx = 2'd0;
        case (rows_low)
            4'b0001: res.idx = 2'd0;
            4'b0010: res.idx = 2'd1;
            4'b0100: res.idx = 2'd2;
            4'b1000: res.idx = 2'd3;
            default: res.hit = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, loads RESET_VAL into both stages
//   d     : asynchronous input
//   q     : synchronized output
module sync2 #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    assign meta_d = d;
    assign sync_d = meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner with debounce and a two-digit history.
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   rows      : row lines, active-low, pulled up, asynchronous
//   cols      : column drive, active-low one-hot
//   key_code  : hex value of the last accepted key
//   key_valid : one-cycle pulse per accepted press
//   key_held  : high while the accepted key stays pressed
//   digit_new : most recent accepted digit
//   digit_old : previous accepted digit
//
// state    | meaning
// ---------+-------------------------------------------------------------
// SCAN     | drive each column SCAN_DIV cycles, sample rows on last cycle
// DEBOUNCE | column held, row pattern must stay stable DEBOUNCE_CYCLES
// HELD     | key accepted, watching only the latched row for release
// RELEASE  | latched row high, must stay high DEBOUNCE_CYCLES to finish
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 48000,
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);

    // One counter serves both the scan dwell and the debounce timers, so it
    // is sized for the larger of the two; every state exits at its own limit.
    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0] rows_s;

    state_e           state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic [3:0]       pat_q, pat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;
    logic [3:0]       digit_new_q, digit_new_d;
    logic [3:0]       digit_old_q, digit_old_d;

    row_hit_t   hit;
    logic [3:0] code;

    sync2 #(
        .WIDTH    (4),
        .RESET_VAL(4'hF)
    ) u_rows_sync (
        .clk  (clk),
        .rst_n(reset),
        .d    (rows),
        .q    (rows_s)
    );

    assign hit  = onehot_row_idx(~rows_s);
    assign code = key_lookup(row_q, col_q);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        pat_d       = pat_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        digit_new_d = digit_new_q;
        digit_old_d = digit_old_q;

        case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (hit.hit) begin
                        row_d   = hit.idx;
                        pat_d   = rows_s;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (rows_s != pat_q) begin
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    key_valid_d = 1'b1;
                    key_code_d  = code;
                    digit_old_d = digit_new_q;
                    digit_new_d = code;
                    key_held_d  = 1'b1;
                    state_d     = HELD;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (rows_s[row_q]) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                if (!rows_s[row_q]) begin
                    // Release bounce: the key is still considered held.
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    key_held_d = 1'b0;
                    state_d    = SCAN;
                    col_d      = col_q + 2'd1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SCAN;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            pat_q       <= 4'hF;
            cnt_q       <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            digit_new_q <= 4'h0;
            digit_old_q <= 4'h0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            pat_q       <= pat_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            digit_new_q <= digit_new_d;
            digit_old_q <= digit_old_d;
        end
    end

    assign cols      = ~(4'b0001 << col_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign digit_new = digit_new_q;
    assign digit_old = digit_old_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [3:0] digit_new;
    logic [3:0] digit_old;

    // keys[r*4+c] = 1 means the key at row r / column c is pressed
    logic [15:0] keys;

    int n_checks  = 0;
    int n_pass    = 0;
    int pulse_cnt = 0;
    int dbl_cnt   = 0;
    logic vld_prev = 1'b0;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rows     (rows),
        .cols     (cols),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held),
        .digit_new(digit_new),
        .digit_old(digit_old)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    always @(posedge clk) begin
        if (key_valid) pulse_cnt <= pulse_cnt + 1;
        if (key_valid && vld_prev) dbl_cnt <= dbl_cnt + 1;
        vld_prev <= key_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(input int base, input string tag);
        int n = 0;
        while (pulse_cnt == base && n < 100) begin
            cyc(1);
            n++;
        end
        chk(tag, 32'(pulse_cnt != base), 32'd1);
    endtask

    task automatic wait_cols(input logic [3:0] tgt, input bit want_eq, input string tag);
        int n = 0;
        while (((cols == tgt) != want_eq) && n < 64) begin
            cyc(1);
            n++;
        end
        chk(tag, 32'((cols == tgt) == want_eq), 32'd1);
    endtask

    int  p;
    bit  held_drop;

    initial begin
        reset = 1'b0;
        keys  = 16'h0;
        cyc(3);
        chk("rst_cols",  cols,      4'b1110);
        chk("rst_code",  key_code,  4'h0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_held",  key_held,  1'b0);
        chk("rst_new",   digit_new, 4'h0);
        chk("rst_old",   digit_old, 4'h0);
        reset = 1'b1;

        // r1/c2 -> 6
        p = pulse_cnt;
        keys[6] = 1'b1;
        wait_pulse(p, "k6_seen");
        cyc(20);
        chk("k6_count", pulse_cnt - p, 1);
        chk("k6_code",  key_code,  4'h6);
        chk("k6_new",   digit_new, 4'h6);
        chk("k6_old",   digit_old, 4'h0);
        chk("k6_held",  key_held,  1'b1);
        chk("k6_cols",  cols,      4'b1011);
        keys = 16'h0;
        cyc(20);
        chk("k6_released", key_held, 1'b0);

        // r0/c2 -> 3
        p = pulse_cnt;
        keys[2] = 1'b1;
        wait_pulse(p, "k3_seen");
        cyc(5);
        chk("k3_code", key_code,  4'h3);
        chk("k3_new",  digit_new, 4'h3);
        chk("k3_old",  digit_old, 4'h6);
        keys = 16'h0;
        cyc(20);
        chk("k3_count", pulse_cnt - p, 1);

        // press bounce on r2/c1 -> 8
        p = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            keys[9] = ~keys[9];
            cyc(2);
        end
        chk("bounce_nopulse", pulse_cnt - p, 0);
        wait_pulse(p, "bounce_seen");
        cyc(10);
        chk("bounce_count", pulse_cnt - p, 1);
        chk("bounce_code",  key_code, 4'h8);
        keys = 16'h0;
        cyc(20);

        // long hold on r3/c1 -> 0, then release with glitches
        p = pulse_cnt;
        keys[13] = 1'b1;
        wait_pulse(p, "hold_seen");
        held_drop = 1'b0;
        repeat (200) begin
            cyc(1);
            if (!key_held) held_drop = 1'b1;
        end
        chk("hold_held",  held_drop, 1'b0);
        chk("hold_code",  key_code,  4'h0);
        chk("hold_count", pulse_cnt - p, 1);
        repeat (2) begin
            keys[13] = 1'b0;
            cyc(3);
            keys[13] = 1'b1;
            cyc(3);
        end
        chk("glitch_held", key_held, 1'b1);
        keys[13] = 1'b0;
        cyc(8);
        chk("rel_held_early", key_held, 1'b1);
        cyc(6);
        chk("rel_held_late", key_held, 1'b0);
        chk("rel_count", pulse_cnt - p, 1);

        // two rows in column 0: rejected, scan keeps rotating
        p = pulse_cnt;
        keys = 16'h0101;
        wait_cols(4'b1110, 1'b0, "mr_leave_c0");
        wait_cols(4'b1110, 1'b1, "mr_enter_c0");
        cyc(4);
        chk("mr_c1", cols, 4'b1101);
        cyc(4);
        chk("mr_c2", cols, 4'b1011);
        cyc(4);
        chk("mr_c3", cols, 4'b0111);
        cyc(4);
        chk("mr_c0", cols, 4'b1110);
        chk("mr_nopulse", pulse_cnt - p, 0);
        keys = 16'h0;
        cyc(4);

        // corner keys r3/c0 -> E, r3/c3 -> D
        p = pulse_cnt;
        keys[12] = 1'b1;
        wait_pulse(p, "kE_seen");
        cyc(3);
        chk("kE_code", key_code, 4'hE);
        keys = 16'h0;
        cyc(20);
        p = pulse_cnt;
        keys[15] = 1'b1;
        wait_pulse(p, "kD_seen");
        cyc(3);
        chk("kD_code", key_code,  4'hD);
        chk("kD_new",  digit_new, 4'hD);
        chk("kD_old",  digit_old, 4'hE);
        keys = 16'h0;
        cyc(20);

        // asynchronous reset while debouncing r1/c1
        keys[5] = 1'b1;
        wait_cols(4'b1101, 1'b0, "rd_leave_c1");
        wait_cols(4'b1101, 1'b1, "rd_enter_c1");
        cyc(6);
        chk("rd_in_debounce", cols, 4'b1101);
        p = pulse_cnt;
        #2 reset = 1'b0;
        #1;
        chk("rd_cols",  cols,      4'b1110);
        chk("rd_valid", key_valid, 1'b0);
        chk("rd_held",  key_held,  1'b0);
        chk("rd_code",  key_code,  4'h0);
        chk("rd_new",   digit_new, 4'h0);
        chk("rd_old",   digit_old, 4'h0);
        cyc(20);
        keys = 16'h0;
        reset = 1'b1;
        cyc(20);
        chk("rd_nopulse", pulse_cnt - p, 0);

        chk("no_double_valid", dbl_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
